// File: rtl/sqrt_seq_ctrl.sv
// Sequential square-root engine: bit-serial restoring root, then decimal split into whole.hundredths.
// Define SQRT_ROUND_EN to round to the nearest hundredth instead of truncating.
module sqrt_seq_ctrl #(
  parameter int IN_W = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] number_in,
  output logic            busy,
  output logic            done,
  output logic            result_valid,
  output logic [6:0]      whole,
  output logic [6:0]      fracture
);

`ifdef SQRT_ROUND_EN
  localparam int unsigned SCALE = 40000;
  localparam int unsigned XW    = IN_W + 16;
`else
  localparam int unsigned SCALE = 10000;
  localparam int unsigned XW    = IN_W + 14;
`endif
  localparam int unsigned ITER = (XW + 1) / 2;
  localparam int unsigned PW   = 2 * ITER;
  localparam int unsigned RW   = ITER + 2;
  localparam int unsigned CW   = $clog2(ITER + 1);

  localparam logic [PW-1:0]   SCALE_V = PW'(SCALE);
  localparam logic [ITER-1:0] HUNDRED = ITER'(100);
  localparam logic [CW-1:0]   LAST    = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROOT,
    S_CONV,
    S_DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   x_sr;
  logic [ITER-1:0] root;
  logic [RW-1:0]   rmd;
  logic [CW-1:0]   cnt;
  logic [ITER-1:0] conv_rem;
  logic [6:0]      wcnt;

  logic [PW-1:0]   x_init;
  logic [RW-1:0]   rmd_sh;
  logic [RW-1:0]   trial;
  logic [RW-1:0]   rmd_nxt;
  logic [ITER-1:0] root_nxt;
  logic [ITER-1:0] r_fin;
  logic            ge;

  // One restoring step: bring down two operand bits, try (root<<2)|1.
  always_comb begin
    x_init   = {{(PW-IN_W){1'b0}}, number_in} * SCALE_V;
    rmd_sh   = (rmd << 2) | RW'(x_sr[PW-1:PW-2]);
    trial    = {root, 2'b01};
    ge       = (rmd_sh >= trial);
    rmd_nxt  = ge ? (rmd_sh - trial) : rmd_sh;
    root_nxt = {root[ITER-2:0], ge};
`ifdef SQRT_ROUND_EN
    // Root is in half-hundredths; add one half-step and halve to round half-up.
    r_fin    = ITER'(({1'b0, root_nxt} + (ITER+1)'(1)) >> 1);
`else
    r_fin    = root_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      x_sr         <= '0;
      root         <= '0;
      rmd          <= '0;
      cnt          <= '0;
      conv_rem     <= '0;
      wcnt         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      whole        <= '0;
      fracture     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_sr         <= x_init;
            root         <= '0;
            rmd          <= '0;
            cnt          <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b1;
            state        <= S_ROOT;
          end
        end
        S_ROOT: begin
          x_sr <= x_sr << 2;
          root <= root_nxt;
          rmd  <= rmd_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            conv_rem <= r_fin;
            wcnt     <= '0;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          if (conv_rem >= HUNDRED) begin
            conv_rem <= conv_rem - HUNDRED;
            wcnt     <= wcnt + 1'b1;
          end else begin
            whole        <= wcnt;
            fracture     <= conv_rem[6:0];
            busy         <= 1'b0;
            done         <= 1'b1;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed bench for sqrt_seq_ctrl (default IN_W=9); expectations follow SQRT_ROUND_EN if defined.
module tb_sqrt_seq_ctrl;

`ifdef SQRT_ROUND_EN
  localparam int ITER_T = 13;
  localparam int F5     = 24;
  localparam int F511   = 61;
`else
  localparam int ITER_T = 12;
  localparam int F5     = 23;
  localparam int F511   = 60;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] number_in;
  logic       busy;
  logic       done;
  logic       result_valid;
  logic [6:0] whole;
  logic [6:0] fracture;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_seq_ctrl #(.IN_W(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .number_in    (number_in),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .whole        (whole),
    .fracture     (fracture)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to done; optionally re-pulse start mid-flight.
  task automatic run_op(input string tag, input logic [8:0] n, input int ew, input int ef,
                        input bit disturb);
    int lat;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1;
    number_in = n;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_rv_clr"}, 32'(result_valid), 0);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      busy_ok = busy_ok & busy;
      if (disturb && lat == 3) begin
        start = 1'b1;
        number_in = 9'd511;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(ITER_T + ew + 1));
    chk({tag, "_busy_run"}, 32'(busy_ok), 1);
    chk({tag, "_busy_done"}, 32'(busy), 0);
    chk({tag, "_whole"}, 32'(whole), 32'(ew));
    chk({tag, "_frac"}, 32'(fracture), 32'(ef));
    chk({tag, "_rv_set"}, 32'(result_valid), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int t;
    int nd;
    int d1;
    int d2;

    rst_n = 1'b0;
    start = 1'b0;
    number_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_whole", 32'(whole), 0);
    chk("rst_frac", 32'(fracture), 0);
    rst_n = 1'b1;

    run_op("n0", 9'd0, 0, 0, 1'b0);
    run_op("n1", 9'd1, 1, 0, 1'b0);
    run_op("n2", 9'd2, 1, 41, 1'b0);
    run_op("n5_dist", 9'd5, 2, F5, 1'b1);
    run_op("n511", 9'd511, 22, F511, 1'b0);
    run_op("n324", 9'd324, 18, 0, 1'b0);
    run_op("n360", 9'd360, 18, 97, 1'b0);

    // Asynchronous reset in the middle of a root computation.
    @(negedge clk);
    start = 1'b1;
    number_in = 9'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_whole", 32'(whole), 0);
    chk("mid_rst_frac", 32'(fracture), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("n4_after_rst", 9'd4, 2, 0, 1'b0);

    // Start held high: repeated 10.00 with a single IDLE cycle between runs.
    @(negedge clk);
    start = 1'b1;
    number_in = 9'd100;
    @(negedge clk);
    t = 0;
    nd = 0;
    d1 = -1;
    d2 = -1;
    while (nd < 2 && t < 200) begin
      if (done) begin
        if (nd == 0) d1 = t;
        else d2 = t;
        chk("b2b_whole", 32'(whole), 10);
        chk("b2b_frac", 32'(fracture), 0);
        nd++;
      end
      if (t == ITER_T + 13) chk("b2b_rv_clr", 32'(result_valid), 0);
      if (nd < 2) begin
        @(negedge clk);
        t++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd), 2);
    chk("b2b_d1", 32'(d1), 32'(ITER_T + 11));
    chk("b2b_d2", 32'(d2), 32'(2 * (ITER_T + 11) + 2));
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done), 0);
    chk("b2b_rv_hold", 32'(result_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
